// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper and its settle counter.
package truth_sweep_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    FIN
  } state_t;

  // Three inputs give eight vectors, walked by a 3-bit index
  localparam int N_VEC = 8;
  localparam int IDX_W = 3;

  // Settle counter width; SETTLE values 0..15 fit
  localparam int CNT_W = 4;

  // Index of the final vector, where the sweep stops instead of wrapping
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_VEC - 1);

  // Truth table the default function under test is expected to produce
  localparam logic [N_VEC-1:0] EXP_DEF_TABLE = 8'hA3;

endpackage

// File: rtl/sweep_cnt.sv
// Settle counter: counts the cycles a stimulus vector has been held and flags
// when the programmed settle time has elapsed.
module sweep_cnt
  import truth_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // Count held cycles; park on the terminal value so it never wraps while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(SETTLE));

endmodule

// File: rtl/truth_sweep.sv
// Truth-table sweeper: drives all eight {x,y,z} vectors onto an external
// 3-input function, lets each settle, captures s into table_out and compares
// the captured table against a reference latched at start.
module truth_sweep
  import truth_sweep_pkg::*;
#(
  parameter int               SETTLE  = 1,
  parameter logic [N_VEC-1:0] EXP_DEF = EXP_DEF_TABLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_VEC-1:0] expected,
  input  logic             s,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic             match
);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [N_VEC-1:0]   exp_q;
  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_tc;

  // The settle count restarts on every new vector: at accept and when leaving SAMPLE for HOLD
  assign cnt_clr = ((state == IDLE) && start) || ((state == SAMPLE) && (idx != IDX_LAST));
  assign cnt_en  = (state == HOLD);

  sweep_cnt #(
    .SETTLE(SETTLE)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  // Sweep sequencer: steps the vector, captures s once per vector, and reports the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      {x, y, z} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      match     <= 1'b0;
      exp_q     <= EXP_DEF;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= HOLD;
            idx       <= '0;
            {x, y, z} <= 3'b000;
            busy      <= 1'b1;
            exp_q     <= expected;
            table_out <= '0;
            match     <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_out[idx] <= s;
          if (idx != IDX_LAST) begin
            idx       <= idx + IDX_W'(1);
            {x, y, z} <= idx + IDX_W'(1);
            state     <= HOLD;
          end else begin
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          match <= (table_out == exp_q);
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_sweep.sv
// Self-checking bench for truth_sweep: one instance with SETTLE=1 under directed
// and randomized sweeps, and one with SETTLE=0 with start held high throughout.
module tb_truth_sweep;

  localparam int S1 = 1;
  localparam int S0 = 0;
  localparam int FUT_POS  = 0;
  localparam int FUT_ONE  = 1;
  localparam int FUT_RAND = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst0_n = 1'b0;

  logic       start = 1'b0;
  logic [7:0] expected = 8'hA3;
  logic       s;
  logic       x, y, z, busy, done, match;
  logic [7:0] table_out;

  logic       start0 = 1'b0;
  logic [7:0] expected0 = 8'hA3;
  logic       s0;
  logic       x0, y0, z0, busy0, done0, match0;
  logic [7:0] table_out0;

  int         fut_mode = FUT_POS;
  logic       glitch_en = 1'b0;
  logic       noise = 1'b0;
  logic       sample_now = 1'b0;
  logic [7:0] rand_tab = 8'h00;
  logic       fut_val;

  int checks = 0;
  int failures = 0;

  // Behavioural model state, index 0 = SETTLE=1 instance, index 1 = SETTLE=0 instance
  logic       m_act[2];
  int         m_k[2];
  logic [2:0] m_vec[2];
  logic       m_busy[2];
  logic       m_done[2];
  logic [7:0] m_tab[2];
  logic [7:0] m_exp[2];
  logic       m_match[2];

  // SETTLE=0 instance monitor
  logic mon0_on = 1'b0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   sweeps0 = 0;
  logic busy0_prev = 1'b0;
  logic done0_prev = 1'b0;

  always #5 clk = ~clk;

  truth_sweep #(.SETTLE(S1), .EXP_DEF(8'hA3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .s(s),
    .x(x), .y(y), .z(z), .busy(busy), .done(done), .table_out(table_out), .match(match)
  );

  truth_sweep #(.SETTLE(S0), .EXP_DEF(8'hA3)) dut0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .expected(expected0), .s(s0),
    .x(x0), .y(y0), .z(z0), .busy(busy0), .done(done0), .table_out(table_out0), .match(match0)
  );

  // Product of maxterms for the zeros of table A3 (vectors 010, 011, 100, 110)
  function automatic logic pos_fn(input logic a, input logic b, input logic c);
    return (a | ~b | c) & (a | ~b | ~c) & (~a | b | c) & (~a | ~b | c);
  endfunction

  // Function under test for the SETTLE=1 instance, optionally with noise outside SAMPLE
  always_comb begin
    fut_val = pos_fn(x, y, z);
    if (fut_mode == FUT_ONE) fut_val = 1'b1;
    else if (fut_mode == FUT_RAND) fut_val = rand_tab[{x, y, z}];
  end
  assign s  = (glitch_en && !sample_now) ? noise : fut_val;
  assign s0 = pos_fn(x0, y0, z0);

  // Noise toggles every cycle, away from the sampling edge
  always @(negedge clk) noise = ~noise;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Model: k = edges since accept, P = SETTLE+2 cycles per vector; vector v is
  // captured at edge (v+1)*P and done follows at edge 8*P+1
  task automatic model_step(input int i, input bit rst_low, input logic st,
                            input logic sv, input logic [7:0] ex);
    int p;
    p = (i == 0) ? S1 + 2 : S0 + 2;
    if (rst_low) begin
      m_act[i] = 1'b0; m_k[i] = 0; m_vec[i] = 3'd0; m_busy[i] = 1'b0;
      m_done[i] = 1'b0; m_tab[i] = 8'h00; m_match[i] = 1'b0; m_exp[i] = 8'hA3;
    end else begin
      m_done[i] = 1'b0;
      if (m_act[i]) begin
        m_k[i]++;
        if ((m_k[i] % p) == 0 && m_k[i] <= 8 * p) m_tab[i][m_k[i] / p - 1] = sv;
        if (m_k[i] / p <= 7) m_vec[i] = 3'(m_k[i] / p);
        if (m_k[i] == 8 * p + 1) begin
          m_act[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b1;
          m_match[i] = (m_tab[i] == m_exp[i]);
        end
      end else if (st) begin
        m_act[i] = 1'b1; m_k[i] = 0; m_vec[i] = 3'd0; m_busy[i] = 1'b1;
        m_exp[i] = ex; m_tab[i] = 8'h00; m_match[i] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n)  model_step(0, !rst_n, start, s, expected);
  always @(posedge clk or negedge rst0_n) model_step(1, !rst0_n, start0, s0, expected0);

  // Compare both instances against the model every cycle, then mark SAMPLE cycles for the noise mux
  always @(posedge clk) begin
    #1;
    checkOutput("dut_xyz",     32'({x, y, z}),     32'(m_vec[0]));
    checkOutput("dut_busy",    32'(busy),          32'(m_busy[0]));
    checkOutput("dut_done",    32'(done),          32'(m_done[0]));
    checkOutput("dut_table",   32'(table_out),     32'(m_tab[0]));
    checkOutput("dut_match",   32'(match),         32'(m_match[0]));
    checkOutput("dut0_xyz",    32'({x0, y0, z0}),  32'(m_vec[1]));
    checkOutput("dut0_busy",   32'(busy0),         32'(m_busy[1]));
    checkOutput("dut0_done",   32'(done0),         32'(m_done[1]));
    checkOutput("dut0_table",  32'(table_out0),    32'(m_tab[1]));
    checkOutput("dut0_match",  32'(match0),        32'(m_match[1]));
    sample_now = m_act[0] && ((m_k[0] % (S1 + 2)) == S1 + 1) && (m_k[0] < 8 * (S1 + 2));
  end

  // SETTLE=0 with start held: done 17 cycles after each accept, busy low for one cycle between sweeps
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon0_on) begin
      if (busy0 && !busy0_prev) rise_cyc = cyc;
      if (done0) begin
        checkOutput("settle0_latency", 32'(cyc - rise_cyc), 32'd17);
        checkOutput("settle0_table",   32'(table_out0),     32'hA3);
        checkOutput("settle0_match",   32'(match0),         32'd1);
        checkOutput("settle0_gap",     32'(busy0),          32'd0);
        sweeps0++;
      end
      if (done0_prev) checkOutput("settle0_restart", 32'(busy0), 32'd1);
    end
    busy0_prev = busy0;
    done0_prev = done0;
  end

  // One sweep: accept on the first edge, then watch 40 cycles for done pulses
  task automatic applyStimulus(input logic [7:0] exp_in, input bit repulse, input bit mid_reset,
                               output int first_done, output int n_done);
    first_done = -1;
    n_done = 0;
    expected = exp_in;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      expected = 8'($urandom);
      if (repulse && (c == 5 || c == 12)) start = 1'b1;
      if (mid_reset && c == 10) rst_n = 1'b0;
      if (mid_reset && c == 12) rst_n = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (mid_reset && c == 10) begin
        checkOutput("midreset_busy",  32'(busy),        32'd0);
        checkOutput("midreset_xyz",   32'({x, y, z}),   32'd0);
        checkOutput("midreset_table", 32'(table_out),   32'd0);
      end
    end
  endtask

  initial begin
    int fd;
    int nd;
    logic [7:0] exp_r;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_xyz",   32'({x, y, z}), 32'd0);
    checkOutput("reset_busy",  32'(busy),      32'd0);
    checkOutput("reset_done",  32'(done),      32'd0);
    checkOutput("reset_table", 32'(table_out), 32'd0);
    checkOutput("reset_match", 32'(match),     32'd0);
    rst_n = 1'b1;
    rst0_n = 1'b1;
    @(posedge clk); #2;
    start0 = 1'b1;
    mon0_on = 1'b1;

    $display("[TB] good PoS function, single start");
    applyStimulus(8'hA3, 1'b0, 1'b0, fd, nd);
    checkOutput("good_latency", 32'(fd),          32'd25);
    checkOutput("good_ndone",   32'(nd),          32'd1);
    checkOutput("good_table",   32'(table_out),   32'hA3);
    checkOutput("good_match",   32'(match),       32'd1);
    checkOutput("good_xyz_end", 32'({x, y, z}),   32'd7);

    $display("[TB] s tied high");
    fut_mode = FUT_ONE;
    applyStimulus(8'hA3, 1'b0, 1'b0, fd, nd);
    checkOutput("ones_table", 32'(table_out), 32'hFF);
    checkOutput("ones_match", 32'(match),     32'd0);

    $display("[TB] start re-pulsed mid sweep");
    fut_mode = FUT_POS;
    applyStimulus(8'hA3, 1'b1, 1'b0, fd, nd);
    checkOutput("repulse_latency", 32'(fd), 32'd25);
    checkOutput("repulse_ndone",   32'(nd), 32'd1);

    $display("[TB] reset mid sweep");
    applyStimulus(8'hA3, 1'b0, 1'b1, fd, nd);
    checkOutput("midreset_ndone", 32'(nd), 32'd0);
    applyStimulus(8'hA3, 1'b0, 1'b0, fd, nd);
    checkOutput("after_reset_latency", 32'(fd),        32'd25);
    checkOutput("after_reset_table",   32'(table_out), 32'hA3);
    checkOutput("after_reset_match",   32'(match),     32'd1);

    $display("[TB] s toggling outside SAMPLE");
    fut_mode = FUT_ONE;
    glitch_en = 1'b1;
    applyStimulus(8'hFF, 1'b0, 1'b0, fd, nd);
    checkOutput("glitch_table", 32'(table_out), 32'hFF);
    checkOutput("glitch_match", 32'(match),     32'd1);

    $display("[TB] randomized tables");
    for (int r = 0; r < 5; r++) begin
      rand_tab = 8'($urandom);
      exp_r = ($urandom_range(0, 1) == 1) ? rand_tab : 8'($urandom);
      glitch_en = 1'($urandom_range(0, 1));
      fut_mode = FUT_RAND;
      applyStimulus(exp_r, 1'b0, 1'b0, fd, nd);
      checkOutput("rand_latency", 32'(fd),        32'd25);
      checkOutput("rand_table",   32'(table_out), 32'(rand_tab));
      checkOutput("rand_match",   32'(match),     32'(rand_tab == exp_r));
    end

    repeat (3) @(posedge clk);
    #2;
    checkOutput("settle0_sweep_count", 32'(sweeps0 >= 5), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
